pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/adder.sv | 18 +
 rtl/multiplexer_4to1.sv | 28 ++
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERROR = 3'd4
    } fetch_state_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] PC_SEL_HOLD   = 2'd0;
    localparam logic [1:0] PC_SEL_PLUS4  = 2'd1;
    localparam logic [1:0] PC_SEL_TARGET = 2'd2;
    localparam logic [1:0] PC_SEL_RESET  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : Unsigned modulo-2^WIDTH adder.
// Revision : 1.0
// ============================================================================
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/multiplexer_4to1.sv
`default_nettype none
// ============================================================================
// Module   : multiplexer_4to1
// Brief    : Four-input multiplexer with a 2-bit select.
// Revision : 1.0
// ============================================================================
module multiplexer_4to1 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Single-outstanding instruction fetch with redirect and stall.
// Revision : 1.0
// ============================================================================
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        misaligned
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d, pc_plus4;
    logic [1:0]   pc_sel;
    logic         imem_req_q, imem_req_d;
    word_t        imem_addr_q, imem_addr_d;
    logic         if_valid_q, if_valid_d;
    word_t        if_instr_q, if_instr_d;
    word_t        if_pc_q, if_pc_d;
    word_t        if_pc_plus4_q, if_pc_plus4_d;
    logic         misaligned_q, misaligned_d;
    logic         redirect_bad;

    adder #(.WIDTH(32)) u_pc_adder (
        .a   (pc_q),
        .b   (32'd4),
        .sum (pc_plus4)
    );

    multiplexer_4to1 #(.WIDTH(32)) u_pc_mux (
        .sel (pc_sel),
        .in0 (pc_q),
        .in1 (pc_plus4),
        .in2 (redirect_target),
        .in3 (RESET_PC),
        .out (pc_d)
    );

    assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        pc_sel        = PC_SEL_HOLD;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        misaligned_d  = misaligned_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                pc_sel  = PC_SEL_RESET;
            end
            S_REQ: begin
                if (redirect_bad) begin
                    state_d      = S_ERROR;
                    misaligned_d = 1'b1;
                    if_valid_d   = 1'b0;
                end else if (redirect_valid) begin
                    // Without an ack the old request is still in flight and must drain.
                    state_d    = imem_ack ? S_REQ : S_DRAIN;
                    pc_sel     = PC_SEL_TARGET;
                    if_valid_d = 1'b0;
                end else if (imem_ack) begin
                    state_d       = S_HOLD;
                    pc_sel        = PC_SEL_PLUS4;
                    if_valid_d    = 1'b1;
                    if_instr_d    = imem_rdata;
                    if_pc_d       = pc_q;
                    if_pc_plus4_d = pc_plus4;
                end
            end
            S_HOLD: begin
                if (redirect_bad) begin
                    state_d      = S_ERROR;
                    misaligned_d = 1'b1;
                    if_valid_d   = 1'b0;
                end else if (redirect_valid) begin
                    state_d    = S_REQ;
                    pc_sel     = PC_SEL_TARGET;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    state_d    = S_REQ;
                    if_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (redirect_bad) begin
                    state_d      = S_ERROR;
                    misaligned_d = 1'b1;
                    if_valid_d   = 1'b0;
                end else begin
                    if (redirect_valid) begin
                        pc_sel = PC_SEL_TARGET;
                    end
                    if (imem_ack) begin
                        state_d = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    // The address only moves when a fresh request starts, keeping it stable while waiting.
    always_comb begin
        imem_req_d  = (state_d == S_REQ) || (state_d == S_DRAIN);
        imem_addr_d = (state_d == S_REQ) ? pc_d : imem_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign misaligned  = misaligned_q;

endmodule
`default_nettype wire
